// File: rtl/lab2_pkg.sv
// lab2_pkg: shared state encoding and default operand width for the serial subtractor
package lab2_pkg;
   localparam int WIDTH_DEF = 4;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/lab2_serial_sub_ctrl_if.sv
// lab2_serial_sub_ctrl_if: request/result bundle
// master drives start/a/b and observes diff/borrow/busy/done; slave is the controller side
interface lab2_serial_sub_ctrl_if import lab2_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             busy;
   logic             done;
   modport master (output start, a, b, input diff, borrow, busy, done);
   modport slave (input start, a, b, output diff, borrow, busy, done);
endinterface

// File: rtl/lab2_full_sub_bit.sv
// lab2_full_sub_bit: one-bit full subtractor from two half subtractors
// ports: x minuend bit, y subtrahend bit, bin borrow in, d difference, bout borrow out
module lab2_full_sub_bit (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1, b1, b2;
   lab2_half_sub u_hs0 (.x(x), .y(y), .d(d1), .bo(b1));
   lab2_half_sub u_hs1 (.x(d1), .y(bin), .d(d), .bo(b2));
   assign bout = b1 | b2;
endmodule

// File: rtl/lab2_half_sub.sv
// lab2_half_sub: one-bit half subtractor
// ports: x minuend bit, y subtrahend bit, d difference, bo borrow out
module lab2_half_sub (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);
   assign d  = x ^ y;
   assign bo = ~x & y;
endmodule

// File: rtl/lab2_serial_sub_ctrl.sv
// lab2_serial_sub_ctrl: LSB-first bit-serial subtractor, one bit per clock
// ports: clk, reset (sync, active-high), bus (slave: start/a/b in, diff/borrow/busy/done out)
module lab2_serial_sub_ctrl import lab2_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
   input  logic                   clk,
   input  logic                   reset,
   lab2_serial_sub_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             d, bout;
   lab2_full_sub_bit u_bit (.x(a_q[0]), .y(b_q[0]), .bin(borrow_q), .d(d), .bout(bout));
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d  = RUN;
            a_d      = bus.a;
            b_d      = bus.b;
            borrow_d = 1'b0;
            cnt_d    = '0;
         end
         RUN: begin
            // diff fills from the MSB so bit 0 lands at the LSB after WIDTH shifts
            diff_d   = {d, diff_q[WIDTH-1:1]};
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            borrow_d = bout;
            cnt_d    = cnt_q + CW'(1);
            state_d  = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
      end
   end
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
endmodule

// File: tb/tb_lab2_serial_sub_ctrl.sv
// tb_lab2_serial_sub_ctrl: scoreboard bench with an operation-level reference model
module tb_lab2_serial_sub_ctrl;
   import lab2_pkg::*;
   localparam int W = WIDTH_DEF;
   logic clk = 1'b0;
   logic reset = 1'b1;
   lab2_serial_sub_ctrl_if #(.WIDTH(W)) bus ();
   lab2_serial_sub_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [W-1:0] d;
      logic         b;
      int           de;
   } exp_t;
   exp_t         q[$];
   int           edge_n = 0;
   int           free_at = 0;
   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] hold_d = '0;
   logic         hold_b = 1'b0;
   logic [W-1:0] pend_d = '0;
   logic         pend_b = 1'b0;
   int           pend_de = -1;
   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, edge_n);
      end
   endtask
   // reference model: an operation is accepted whenever start is seen and the
   // previous operation's WIDTH+2 cycle slot has elapsed; result is plain a-b
   initial forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
         q.delete();
         free_at = edge_n + 1;
         hold_d  = '0;
         hold_b  = 1'b0;
         pend_de = -1;
      end else begin
         if (edge_n == pend_de) begin
            hold_d = pend_d;
            hold_b = pend_b;
         end
         if (bus.start && edge_n >= free_at) begin
            pend_d  = bus.a - bus.b;
            pend_b  = (bus.a < bus.b);
            pend_de = edge_n + W;
            q.push_back('{pend_d, pend_b, pend_de});
            free_at = edge_n + W + 2;
         end
      end
   end
   initial forever begin
      logic exp_busy;
      @(negedge clk);
      exp_busy = (edge_n < free_at - 1);
      chk("busy", int'(bus.busy), int'(exp_busy));
      if (q.size() > 0 && q[0].de <= edge_n) begin
         chk("done", int'(bus.done), 1);
         chk("diff", int'(bus.diff), int'(q[0].d));
         chk("borrow", int'(bus.borrow), int'(q[0].b));
         void'(q.pop_front());
      end else begin
         chk("done_idle", int'(bus.done), 0);
      end
      if (!exp_busy) begin
         chk("hold_diff", int'(bus.diff), int'(hold_d));
         chk("hold_borrow", int'(bus.borrow), int'(hold_b));
      end
   end
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
      bus.start = 1'b1;
      bus.a = x;
      bus.b = y;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      repeat (W + 1) @(negedge clk);
   endtask
   initial begin
      bus.start = 1'b1;
      bus.a = W'(9);
      bus.b = W'(3);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      op(W'(9), W'(3));
      op(W'(3), W'(9));
      op(W'(0), W'(1));
      op(W'(15), W'(15));
      op(W'(15), W'(0));
      bus.start = 1'b1;
      repeat (60) begin
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         @(negedge clk);
      end
      bus.start = 1'b0;
      repeat (W + 2) @(negedge clk);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            op(W'(i), W'(j));
      bus.start = 1'b1;
      bus.a = W'(9);
      bus.b = W'(3);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      op(W'(5), W'(7));
      repeat (300) begin
         if ($urandom_range(0, 39) == 0) reset = 1'b1;
         bus.start = 1'($urandom_range(0, 1));
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         @(negedge clk);
         reset = 1'b0;
      end
      bus.start = 1'b0;
      repeat (W + 3) @(negedge clk);
      chk("drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
